// File: rtl/ser_queue_ctrl.sv
// ser_queue_ctrl: serial receive -> DEPTH-entry FIFO -> serial transmit, plus a
// free-running clk_div output. Frames are start(0), WIDTH data bits LSB first,
// [even parity], stop(1). One serial bit per ser_clk cycle.
// Optional feature macro: SER_QUEUE_PARITY_EN adds an even-parity bit to every
// frame (RX_PAR / TX_PAR states) and drives par_err; without it par_err is 0.
// rx_state_dbg / tx_state_dbg expose the raw FSM state encodings.
module ser_queue_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int DIV   = 4
) (
   input  logic                   ser_clk,
   input  logic                   reset,
   input  logic                   ser_in,
   input  logic                   tx_en,
   input  logic                   clr_err,
   output logic                   ser_out,
   output logic                   clk_div,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full,
   output logic                   overflow,
   output logic                   frame_err,
   output logic                   par_err,
   output logic [1:0]             rx_state_dbg,
   output logic [2:0]             tx_state_dbg
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(WIDTH);
   localparam int DW = $clog2(DIV);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV / 2 - 1);

`ifdef SER_QUEUE_PARITY_EN
   typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_DATA = 2'd1, RX_STOP = 2'd2,
                             RX_PAR = 2'd3} rx_state_t;
   typedef enum logic [2:0] {TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2,
                             TX_STOP = 3'd3, TX_PAR = 3'd4} tx_state_t;
`else
   typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_DATA = 2'd1,
                             RX_STOP = 2'd2} rx_state_t;
   typedef enum logic [2:0] {TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2,
                             TX_STOP = 3'd3} tx_state_t;
`endif

   rx_state_t        rx_state;
   tx_state_t        tx_state;
   logic [BW-1:0]    rx_cnt;
   logic [WIDTH-1:0] rx_shift;
   logic [BW-1:0]    tx_cnt;
   logic [WIDTH-1:0] tx_shift;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [DW-1:0]    div_cnt;

`ifdef SER_QUEUE_PARITY_EN
   logic             rx_par_bad;
   logic             tx_par;
   logic             perr_ev;
`endif

   // FIFO handshake: push is offered by a good frame in RX_STOP and is taken
   // when the FIFO is not full or a pop happens on the same edge; pop is taken
   // whenever the transmitter is free (TX_IDLE or finishing TX_STOP), tx_en is
   // high and the FIFO is not empty. A refused push is dropped and flagged.
   logic             pop;
   logic             push;
   logic             good_frame;
   logic             ovf_ev;
   logic             ferr_ev;

   assign rx_state_dbg = rx_state;
   assign tx_state_dbg = tx_state;

   // Push/pop decisions and error events for the current cycle.
   always_comb begin
      pop        = 1'b0;
      push       = 1'b0;
      good_frame = 1'b0;
      ovf_ev     = 1'b0;
      ferr_ev    = 1'b0;
`ifdef SER_QUEUE_PARITY_EN
      perr_ev    = 1'b0;
      perr_ev    = (rx_state == RX_PAR) && (ser_in != (^rx_shift));
      good_frame = (rx_state == RX_STOP) && ser_in && !rx_par_bad;
`else
      good_frame = (rx_state == RX_STOP) && ser_in;
`endif
      pop     = ((tx_state == TX_IDLE) || (tx_state == TX_STOP)) && tx_en && !empty;
      push    = good_frame && (!full || pop);
      ovf_ev  = good_frame && full && !pop;
      ferr_ev = (rx_state == RX_STOP) && !ser_in;
   end

   // Receive FSM: detect start bit, shift data in LSB first, check stop bit.
   always_ff @(posedge ser_clk or posedge reset) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_shift <= '0;
`ifdef SER_QUEUE_PARITY_EN
         rx_par_bad <= 1'b0;
`endif
      end else begin
         case (rx_state)
            RX_IDLE: begin
               if (!ser_in) begin
                  rx_state <= RX_DATA;
                  rx_cnt   <= '0;
               end
            end
            RX_DATA: begin
               rx_shift <= {ser_in, rx_shift[WIDTH-1:1]};
               if (rx_cnt == LAST_BIT) begin
`ifdef SER_QUEUE_PARITY_EN
                  rx_state <= RX_PAR;
`else
                  rx_state <= RX_STOP;
`endif
               end else begin
                  rx_cnt <= rx_cnt + BW'(1);
               end
            end
`ifdef SER_QUEUE_PARITY_EN
            RX_PAR: begin
               rx_par_bad <= perr_ev;
               rx_state   <= RX_STOP;
            end
`endif
            RX_STOP: begin
               // Always back to idle so a start bit on the next edge is seen.
               rx_state <= RX_IDLE;
`ifdef SER_QUEUE_PARITY_EN
               rx_par_bad <= 1'b0;
`endif
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // FIFO storage; written at the stop-bit edge of an accepted frame.
   always_ff @(posedge ser_clk) begin
      if (push) begin
         mem[wr_ptr] <= rx_shift;
      end
   end

   // FIFO pointers and registered occupancy / full / empty.
   always_ff @(posedge ser_clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
            empty <= 1'b0;
            full  <= (count == CW'(DEPTH - 1));
         end else if (pop && !push) begin
            count <= count - CW'(1);
            full  <= 1'b0;
            empty <= (count == CW'(1));
         end
      end
   end

   // Transmit FSM: pop head word, send start, data LSB first, [parity], stop.
   always_ff @(posedge ser_clk or posedge reset) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         ser_out  <= 1'b1;
         tx_cnt   <= '0;
         tx_shift <= '0;
`ifdef SER_QUEUE_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else begin
         case (tx_state)
            TX_IDLE, TX_STOP: begin
               // The edge that ends the stop bit may start the next frame.
               if (pop) begin
                  tx_shift <= mem[rd_ptr];
`ifdef SER_QUEUE_PARITY_EN
                  tx_par   <= ^mem[rd_ptr];
`endif
                  ser_out  <= 1'b0;
                  tx_state <= TX_START;
               end else begin
                  ser_out  <= 1'b1;
                  tx_state <= TX_IDLE;
               end
            end
            TX_START: begin
               ser_out  <= tx_shift[0];
               tx_shift <= tx_shift >> 1;
               tx_cnt   <= '0;
               tx_state <= TX_DATA;
            end
            TX_DATA: begin
               if (tx_cnt == LAST_BIT) begin
`ifdef SER_QUEUE_PARITY_EN
                  ser_out  <= tx_par;
                  tx_state <= TX_PAR;
`else
                  ser_out  <= 1'b1;
                  tx_state <= TX_STOP;
`endif
               end else begin
                  ser_out  <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
                  tx_cnt   <= tx_cnt + BW'(1);
               end
            end
`ifdef SER_QUEUE_PARITY_EN
            TX_PAR: begin
               ser_out  <= 1'b1;
               tx_state <= TX_STOP;
            end
`endif
            default: begin
               ser_out  <= 1'b1;
               tx_state <= TX_IDLE;
            end
         endcase
      end
   end

   // Sticky error flags: a new event on the clearing cycle keeps the flag set.
   always_ff @(posedge ser_clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
`ifdef SER_QUEUE_PARITY_EN
         par_err   <= 1'b0;
`endif
      end else begin
         overflow  <= (overflow & ~clr_err) | ovf_ev;
         frame_err <= (frame_err & ~clr_err) | ferr_ev;
`ifdef SER_QUEUE_PARITY_EN
         par_err   <= (par_err & ~clr_err) | perr_ev;
`endif
      end
   end

`ifndef SER_QUEUE_PARITY_EN
   assign par_err = 1'b0;
`endif

   // Clock divider: toggle every DIV/2 cycles, starting low after reset.
   always_ff @(posedge ser_clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         clk_div <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         clk_div <= ~clk_div;
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

endmodule

// File: tb/tb_ser_queue_ctrl.sv
// Bench for ser_queue_ctrl (WIDTH=8, DEPTH=4, DIV=4). A timeline model tracks
// the FIFO as a queue of words, the transmitter as "frame started at edge N",
// and clk_div as a function of edges since reset; every cycle all outputs are
// compared against it. Directed table vectors and hand sequences cover the
// fill/overflow, framing error, push+pop at full and reset corner cases.
module tb_ser_queue_ctrl;

   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int DIV   = 4;
`ifdef SER_QUEUE_PARITY_EN
   localparam int FL  = W + 3;
   localparam bit PAR = 1'b1;
`else
   localparam int FL  = W + 2;
   localparam bit PAR = 1'b0;
`endif

   logic       ser_clk = 1'b0;
   logic       reset   = 1'b0;
   logic       ser_in  = 1'b1;
   logic       tx_en   = 1'b0;
   logic       clr_err = 1'b0;
   logic       ser_out;
   logic       clk_div;
   logic [2:0] count;
   logic       empty;
   logic       full;
   logic       overflow;
   logic       frame_err;
   logic       par_err;
   logic [1:0] rx_dbg;
   logic [2:0] tx_dbg;

   ser_queue_ctrl #(.WIDTH(W), .DEPTH(DEPTH), .DIV(DIV)) dut (
      .ser_clk      (ser_clk),
      .reset        (reset),
      .ser_in       (ser_in),
      .tx_en        (tx_en),
      .clr_err      (clr_err),
      .ser_out      (ser_out),
      .clk_div      (clk_div),
      .count        (count),
      .empty        (empty),
      .full         (full),
      .overflow     (overflow),
      .frame_err    (frame_err),
      .par_err      (par_err),
      .rx_state_dbg (rx_dbg),
      .tx_state_dbg (tx_dbg)
   );

   // Clock.
   always #5 ser_clk = ~ser_clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state.
   logic [W-1:0] exp_q[$];
   int           cyc      = 0;
   int           div_n    = 0;
   int           tx_start = -1000;
   int           tx_ok    = 0;
   logic [W-1:0] tx_word  = '0;
   bit           m_ovf, m_ferr, m_perr;

   // Events the driver announces for the edge it is about to cross.
   bit           ev_stop, ev_stop_bit, ev_par_bad, frame_par_bad;
   logic [W-1:0] ev_data;
   bit           rand_mode;

   typedef struct {
      logic [W-1:0] data;
      logic         stop_bit;
      logic [2:0]   exp_count;
      logic         exp_full;
      logic         exp_ovf;
      logic         exp_ferr;
   } vec_t;

   vec_t vtab[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected line level: position within the current transmit frame.
   function automatic logic exp_line();
      int t;
      t = cyc - tx_start;
      if (t < 0 || t >= FL) return 1'b1;
      if (t == 0) return 1'b0;
      if (t <= W) return tx_word[t-1];
      if (PAR && t == W + 1) return ^tx_word;
      return 1'b1;
   endfunction

   // One clock edge: advance model, then compare all outputs.
   task automatic tick();
      bit pop;
      if (rand_mode) begin
         tx_en   = ($urandom_range(0, 3) != 0);
         clr_err = ($urandom_range(0, 15) == 0);
      end
      @(posedge ser_clk);
      #1;
      cyc++;
      div_n++;
      pop = (cyc >= tx_ok) && tx_en && (exp_q.size() > 0);
      if (pop) begin
         tx_word  = exp_q.pop_front();
         tx_start = cyc;
         tx_ok    = cyc + FL;
      end
      if (clr_err) begin
         m_ovf  = 1'b0;
         m_ferr = 1'b0;
         m_perr = 1'b0;
      end
      if (ev_par_bad) m_perr = 1'b1;
      if (ev_stop) begin
         if (!ev_stop_bit) m_ferr = 1'b1;
         else if (!frame_par_bad) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(ev_data);
            else m_ovf = 1'b1;
         end
      end
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      chk("par_err", 32'(par_err), 32'(m_perr));
      chk("ser_out", 32'(ser_out), 32'(exp_line()));
      chk("clk_div", 32'(clk_div), 32'((div_n / (DIV / 2)) % 2));
   endtask

   task automatic idle(input int n);
      ser_in = 1'b1;
      repeat (n) tick();
   endtask

   task automatic send_frame(input logic [W-1:0] d, input bit stop_bit, input bit par_ok,
                             input bit en_at_stop);
      ser_in = 1'b0;
      tick();
      for (int i = 0; i < W; i++) begin
         ser_in = d[i];
         tick();
      end
      frame_par_bad = PAR && !par_ok;
`ifdef SER_QUEUE_PARITY_EN
      ser_in     = (^d) ^ !par_ok;
      ev_par_bad = !par_ok;
      tick();
      ev_par_bad = 1'b0;
`endif
      ser_in      = stop_bit;
      ev_stop     = 1'b1;
      ev_stop_bit = stop_bit;
      ev_data     = d;
      if (en_at_stop) tx_en = 1'b1;
      tick();
      ev_stop       = 1'b0;
      frame_par_bad = 1'b0;
      ser_in        = 1'b1;
   endtask

   task automatic do_reset(input bit async_chk);
      reset = 1'b1;
      #1;
      if (async_chk) begin
         chk("rst_async_ser_out", 32'(ser_out), 32'd1);
         chk("rst_async_count", 32'(count), 32'd0);
      end
      @(posedge ser_clk);
      #1;
      chk("rst_ser_out", 32'(ser_out), 32'd1);
      chk("rst_clk_div", 32'(clk_div), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_par_err", 32'(par_err), 32'd0);
      ser_in   = 1'b1;
      exp_q.delete();
      tx_start = -1000;
      tx_ok    = 0;
      m_ovf    = 1'b0;
      m_ferr   = 1'b0;
      m_perr   = 1'b0;
      div_n    = 0;
      reset    = 1'b0;
   endtask

   initial begin
      logic [7:0]   div_pat;
      logic [W-1:0] part;
      logic [W-1:0] d;

      vtab[0] = '{8'h01, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
      vtab[1] = '{8'h02, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
      vtab[2] = '{8'h03, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
      vtab[3] = '{8'h04, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
      vtab[4] = '{8'h05, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0};
      vtab[5] = '{8'h3C, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1};
      div_pat = 8'b0110_0110;

      do_reset(1'b0);

      // Single frame 0xA5: start bit appears one edge after the stop edge.
      tx_en = 1'b1;
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
      chk("a5_count_at_stop", 32'(count), 32'd1);
      chk("a5_line_idle_at_stop", 32'(ser_out), 32'd1);
      tick();
      chk("a5_start_bit", 32'(ser_out), 32'd0);
      chk("a5_count_after_pop", 32'(count), 32'd0);
      idle(FL + 3);
      chk("a5_drained", 32'(empty), 32'd1);

      // Fill / overflow / framing error table with transmitter held off.
      tx_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         send_frame(vtab[i].data, vtab[i].stop_bit, 1'b1, 1'b0);
         chk("tab_count", 32'(count), 32'(vtab[i].exp_count));
         chk("tab_full", 32'(full), 32'(vtab[i].exp_full));
         chk("tab_overflow", 32'(overflow), 32'(vtab[i].exp_ovf));
         chk("tab_frame_err", 32'(frame_err), 32'(vtab[i].exp_ferr));
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_overflow", 32'(overflow), 32'd0);
      chk("clr_frame_err", 32'(frame_err), 32'd0);
      chk("clr_count_kept", 32'(count), 32'd4);
      tx_en = 1'b1;
      idle(4 * FL + 4);
      chk("fill_drained", 32'(empty), 32'd1);

      // Push and pop on the same edge while full.
      tx_en = 1'b0;
      send_frame(8'h11, 1'b1, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b1, 1'b0);
      send_frame(8'h33, 1'b1, 1'b1, 1'b0);
      send_frame(8'h44, 1'b1, 1'b1, 1'b0);
      chk("pp_full_before", 32'(full), 32'd1);
      send_frame(8'h77, 1'b1, 1'b1, 1'b1);
      chk("pp_count_kept", 32'(count), 32'd4);
      chk("pp_no_overflow", 32'(overflow), 32'd0);
      idle(5 * FL + 4);
      chk("pp_drained", 32'(empty), 32'd1);

      // Reset while both RX and TX are mid-frame (after 4th data bit).
      tx_en = 1'b0;
      send_frame(8'hC3, 1'b1, 1'b1, 1'b0);
      send_frame(8'h99, 1'b1, 1'b1, 1'b0);
      tx_en  = 1'b1;
      part   = 8'h5A;
      ser_in = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         ser_in = part[i];
         tick();
      end
      chk("mid_tx_bit3_low", 32'(ser_out), 32'd0);
      do_reset(1'b1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("div_pattern", 32'(clk_div), 32'(div_pat[i]));
      end
      send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
      chk("post_rst_count", 32'(count), 32'd1);
      idle(FL + 4);
      chk("post_rst_drained", 32'(empty), 32'd1);

`ifdef SER_QUEUE_PARITY_EN
      // Wrong parity drops the word; correct parity is re-sent with parity 1.
      send_frame(8'h07, 1'b1, 1'b0, 1'b0);
      chk("par_err_set", 32'(par_err), 32'd1);
      chk("par_dropped", 32'(count), 32'd0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      chk("par_ok_count", 32'(count), 32'd1);
      idle(FL + 4);
`endif

      // Randomised traffic: random data, bad stop/parity, gaps, tx_en, clr_err.
      rand_mode = 1'b1;
      for (int f = 0; f < 250; f++) begin
         d = W'($urandom);
         send_frame(d, $urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0, 1'b0);
         idle($urandom_range(0, 3));
      end
      rand_mode = 1'b0;
      clr_err   = 1'b0;
      tx_en     = 1'b1;
      idle((DEPTH + 1) * FL + 4);
      chk("rand_drained", 32'(empty), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
